// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

    // Width of the bit counter that walks WIDTH operand bits.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_addsub_bit.sv
// One-bit full adder slice; the carry is registered by the caller.
module addsub_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one slice plus registered carry.
// Define SERIAL_ADDSUB_OVF_EN to build the signed-overflow flag; otherwise ovf is 0.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_ns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int              CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             slice_s, slice_c;
    logic             accept;
    logic             last;

    addsub_bit u_slice (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_c)
    );

    assign accept = (state_q == IDLE) && in_valid;
    assign last   = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Subtract is a + ~b + 1: invert b on load and seed the carry with the +1.
    always_comb begin
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        if (accept) begin
            opa_d   = a;
            opb_d   = (add_ns == OP_ADD) ? b : ~b;
            carry_d = (add_ns == OP_SUB);
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            opa_d    = {1'b0, opa_q[WIDTH-1:1]};
            opb_d    = {1'b0, opb_q[WIDTH-1:1]};
            result_d = {slice_s, result_q[WIDTH-1:1]};
            carry_d  = slice_c;
            cnt_d    = cnt_q + CW'(1);
            if (last) cout_d = slice_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow when the carry into the MSB differs from the carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == RUN && last) ovf_d = carry_q ^ slice_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub at WIDTH = 8.
module tb_serial_addsub;

    localparam int W = 8;
`ifdef SERIAL_ADDSUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         add_ns;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int tests_run;
    int tests_failed;

    serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .add_ns    (add_ns),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set and wait for out_valid; lat counts edges after the accept edge.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic op,
                         output int lat, output bit timed_out);
        int guard;
        timed_out = 1'b0;
        lat = 0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a = oa;
        b = ob;
        add_ns = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid || guard >= 50) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({in_ready, out_valid, result, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b res=%h c=%b o=%b, expected rdy=1 vld=0 res=00 c=0 o=0",
                     in_ready, out_valid, result, cout, ovf);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        logic [W-1:0] va [3] = '{8'h05, 8'hFF, 8'h7F};
        logic [W-1:0] vb [3] = '{8'h03, 8'h01, 8'h01};
        logic [W-1:0] er [3] = '{8'h08, 8'h00, 8'h80};
        logic         ec [3] = '{1'b0, 1'b1, 1'b0};
        logic         eo [3];
        int lat;
        bit to;
        eo[0] = 1'b0;
        eo[1] = 1'b0;
        eo[2] = OVF_ON;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b1, lat, to);
            tests_run++;
            if (to || lat != W) begin
                tests_failed++;
                $display("[TB] FAIL add_latency[%0d]: got %0d cycles (timeout=%0b), expected %0d", i, lat, to, W);
            end
            tests_run++;
            if ({result, cout, ovf} !== {er[i], ec[i], eo[i]}) begin
                tests_failed++;
                $display("[TB] FAIL add_result[%0d]: got res=%h c=%b o=%b, expected res=%h c=%b o=%b",
                         i, result, cout, ovf, er[i], ec[i], eo[i]);
            end
            tick();
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] va [3] = '{8'h05, 8'h03, 8'h80};
        logic [W-1:0] vb [3] = '{8'h03, 8'h05, 8'h01};
        logic [W-1:0] er [3] = '{8'h02, 8'hFE, 8'h7F};
        logic         ec [3] = '{1'b1, 1'b0, 1'b1};
        logic         eo [3];
        int lat;
        bit to;
        eo[0] = 1'b0;
        eo[1] = 1'b0;
        eo[2] = OVF_ON;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], 1'b0, lat, to);
            tests_run++;
            if (to || {result, cout, ovf} !== {er[i], ec[i], eo[i]}) begin
                tests_failed++;
                $display("[TB] FAIL sub_result[%0d]: got res=%h c=%b o=%b (timeout=%0b), expected res=%h c=%b o=%b",
                         i, result, cout, ovf, to, er[i], ec[i], eo[i]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, 1'b1, lat, to);
        tests_run++;
        if (to || {result, cout} !== {8'h46, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL bp_first: got res=%h c=%b (timeout=%0b), expected res=46 c=0", result, cout, to);
        end
        a = 8'h0A;
        b = 8'h05;
        add_ns = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++;
            if ({out_valid, in_ready, result, cout, ovf} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b res=%h c=%b o=%b, expected vld=1 rdy=0 res=46 c=0 o=0",
                         i, out_valid, in_ready, result, cout, ovf);
            end
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, out_valid} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL bp_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
        end
        tick();
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL bp_accept: got rdy=%b, expected rdy=0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        tests_run++;
        if (lat != W || {result, cout, ovf} !== {8'h05, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL bp_queued: got res=%h c=%b o=%b after %0d cycles, expected res=05 c=1 o=0 after %0d",
                     result, cout, ovf, lat, W);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        bit seen;
        out_ready = 1'b1;
        a = 8'h55;
        b = 8'h22;
        add_ns = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({in_ready, out_valid, result, cout, ovf} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: got rdy=%b vld=%b res=%h c=%b o=%b, expected rdy=1 vld=0 res=00 c=0 o=0",
                     in_ready, out_valid, result, cout, ovf);
        end
        seen = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_discard: got out_valid=1 after reset, expected none");
        end
        do_op(8'h10, 8'h20, 1'b1, lat, to);
        tests_run++;
        if (to || {result, cout} !== {8'h30, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL reset_after: got res=%h c=%b (timeout=%0b), expected res=30 c=0", result, cout, to);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va [4] = '{8'h3C, 8'h9A, 8'hC8, 8'h01};
        logic [W-1:0] vb [4] = '{8'h42, 8'h17, 8'h64, 8'h02};
        logic         op [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] er [4] = '{8'h7E, 8'h83, 8'h2C, 8'hFF};
        logic         ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int acc_cyc [4];
        int k;
        int r;
        int cyc;
        bit accepting;
        out_ready = 1'b1;
        k = 0;
        r = 0;
        cyc = 0;
        a = va[0];
        b = vb[0];
        add_ns = op[0];
        in_valid = 1'b1;
        while (r < 4 && cyc < 200) begin
            accepting = in_ready && in_valid;
            tick();
            cyc++;
            if (accepting && k < 4) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 4) begin
                    a = va[k];
                    b = vb[k];
                    add_ns = op[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                tests_run++;
                if ({result, cout, ovf} !== {er[r], ec[r], 1'b0}) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_result[%0d]: got res=%h c=%b o=%b, expected res=%h c=%b o=0",
                             r, result, cout, ovf, er[r], ec[r]);
                end
                r++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (r != 4) begin
            tests_failed++;
            $display("[TB] FAIL b2b_timeout: got %0d results, expected 4", r);
        end
        for (int i = 1; i < k; i++) begin
            tests_run++;
            if (acc_cyc[i] - acc_cyc[i-1] != W + 2) begin
                tests_failed++;
                $display("[TB] FAIL b2b_spacing[%0d]: got %0d cycles, expected %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], W + 2);
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        add_ns = 1'b1;
        out_ready = 1'b1;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor for WIDTH-bit operands. It accepts both operands and an operation select in one handshake. It then resolves one result bit per clock, LSB first, through a single one-bit add/subtract slice with a registered carry, and returns the result, carry-out and optional signed overflow on a valid/ready output. It is the area-minimal sequential counterpart of the parallel add/subtract datapath and sits between an operand producer and a result consumer that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, default 8: operand/result width in bits; legal range WIDTH >= 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- add_ns  in  1  operation select: 1 = a + b, 0 = a - b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  sum/difference, modulo 2^WIDTH.
- cout  out  1  final carry-out; for subtract, 1 = no borrow (a >= b unsigned).
- ovf  out  1  signed overflow flag (see Configuration).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready, latch a and b. If add_ns = 0, latch ~b instead of b. Set carry to !add_ns, clear the bit counter, and go to RUN. Inputs are ignored in all other states.
- RUN: each cycle, the slice takes operand-register bit 0 plus carry and produces sum bit and carry. The sum bit shifts into result[WIDTH-1] and the operand registers shift right by one. The counter increments. When the counter reaches WIDTH-1 the state goes to DONE on the same edge.
- During the MSB cycle, capture the carry into the MSB (for overflow) and the carry out of the MSB (cout).
- DONE: out_valid = 1. result, cout and ovf stay frozen while out_ready = 0. On out_ready = 1 the state goes to IDLE.
- No overlap: in_ready stays 0 throughout RUN and DONE.
- Arithmetic: two's complement subtract is a + ~b + 1, with the +1 supplied as the initial carry. result wraps modulo 2^WIDTH. cout is the unsigned carry/no-borrow.
- Reset takes priority over every other event, including mid-RUN and in DONE with out_ready = 1. The operation in flight is discarded and produces no out_valid.

## Timing
- Reset values, one edge after rst = 1: state IDLE, in_ready = 1, out_valid = 0, result = 0, cout = 0, ovf = 0, counter = 0.
- in_ready and out_valid are decoded directly from registered state, with no combinational path from inputs.
- Latency: when inputs are accepted on edge T, out_valid is high in the cycle following edge T+WIDTH.
- Throughput: one operation per WIDTH+2 cycles at most; this minimum holds when out_ready is held at 1.
- If out_valid && out_ready occurs on edge E, in_ready is 1 after E and a new accept can happen on edge E+1.
- result, cout and ovf are registered. They change only in RUN and on reset, and hold their previous values in IDLE.

## Configuration
- SERIAL_ADDSUB_OVF_EN defined: ovf = carry-into-MSB XOR carry-out-of-MSB, registered in the MSB cycle and held with result.
- SERIAL_ADDSUB_OVF_EN undefined: the overflow logic is absent and the ovf port is tied to 0.

## Structure
- Package serial_addsub_pkg holds:
  - state enum state_t {IDLE, RUN, DONE};
  - constants OP_ADD = 1'b1 and OP_SUB = 1'b0;
  - the function cnt_w(WIDTH), which returns $clog2(WIDTH).
- One sub-module, addsub_bit. It is a combinational one-bit full adder with inputs a, b and cin and outputs s and cout. It is instantiated once, and its carry is registered in serial_addsub.

## Test plan
All scenarios use WIDTH = 8.
- Add 8'h05 + 8'h03 with out_ready = 1 → result 8'h08, cout 0, ovf 0; out_valid asserts exactly 8 cycles after the accept edge.
- Add 8'hFF + 8'h01 → result 8'h00, cout 1, ovf 0. Add 8'h7F + 8'h01 → result 8'h80, ovf 1 with the macro defined and 0 without it.
- Subtract 8'h05 − 8'h03 → 8'h02, cout 1. Subtract 8'h03 − 8'h05 → 8'hFE, cout 0. Subtract 8'h80 − 8'h01 → 8'h7F, ovf 1 with the macro defined.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE and drive in_valid = 1 with new operands. Required: result/cout/ovf stay stable, in_ready stays 0 and the new operands are not accepted. After the out handshake, in_ready = 1 on the next cycle and the queued operands are accepted on the following edge.
- Reset mid-operation: assert rst for one cycle while RUN is at counter 3. Required: the next cycle shows in_ready = 1, out_valid = 0 and result = 0. A following add of 8'h10 + 8'h20 gives 8'h30.
- Back-to-back: 4 random operations with out_ready = 1 and in_valid held high. Required: each result matches the a ± b model, and accepts are spaced exactly WIDTH+2 cycles apart.
